// File: rtl/rtttl_seq_engine.sv
`default_nettype none
// rtttl_seq_engine: plays {octave,note} entries from a writable song memory with
// dotted durations, runtime tempo, articulation gap, loop, pause and stop.
module rtttl_seq_engine #(
  parameter int ADDR_W    = 6,
  parameter int TICK_W    = 16,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [TICK_W-1:0] tick_div,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [3:0]        octave,
  output logic [3:0]        note,
  output logic              note_strobe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);
  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [6:0] GAP   = 7'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PLAY = 2'd2} state_t;

  logic [15:0]       mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]        octave_q, octave_d, note_q, note_d;
  logic [6:0]        dur_q, dur_d, rem_q, rem_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              strobe_q, strobe_d, done_q, done_d, wrap_q, wrap_d;

  logic              e_end, e_dot;
  logic [2:0]        e_dur;
  logic [3:0]        e_oct, e_note;
  logic [6:0]        e_base, e_ticks;
  logic [TICK_W-1:0] div_last;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign e_end  = mem[cur_addr_q][15];
  assign e_dot  = mem[cur_addr_q][14];
  assign e_dur  = mem[cur_addr_q][13:11];
  assign e_oct  = mem[cur_addr_q][7:4];
  assign e_note = mem[cur_addr_q][3:0];

  always_comb begin
    e_base = 7'd1;
    case (e_dur)
      3'd0:    e_base = 7'd64;
      3'd1:    e_base = 7'd32;
      3'd2:    e_base = 7'd16;
      3'd3:    e_base = 7'd8;
      3'd4:    e_base = 7'd4;
      3'd5:    e_base = 7'd2;
      default: e_base = 7'd1;
    endcase
    e_ticks = e_base + (e_dot ? (e_base >> 1) : 7'd0);
  end

  // A zero divider behaves like one cycle per tick.
  assign div_last = (tick_div == '0) ? '0 : tick_div - TICK_W'(1);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    octave_d   = octave_q;
    note_d     = note_q;
    dur_d      = dur_q;
    rem_d      = rem_q;
    tick_d     = tick_q;
    wrap_d     = wrap_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          cur_addr_d = '0;
          wrap_d     = 1'b0;
        end
      end
      S_LOAD: begin
        // wrap_q marks that the last memory slot was just played without an end flag.
        if (e_end || wrap_q) begin
          wrap_d = 1'b0;
          if (loop_en && (cur_addr_q != '0 || wrap_q)) begin
            cur_addr_d = '0;
          end else begin
            state_d  = S_IDLE;
            octave_d = 4'd0;
            note_d   = 4'd0;
            done_d   = 1'b1;
          end
        end else begin
          octave_d = e_oct;
          note_d   = e_note;
          dur_d    = e_ticks;
          rem_d    = e_ticks;
          tick_d   = '0;
          strobe_d = 1'b1;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!pause) begin
          if (tick_q >= div_last) begin
            tick_d = '0;
            rem_d  = rem_q - 7'd1;
            if (rem_q == 7'd1) begin
              state_d    = S_LOAD;
              cur_addr_d = cur_addr_q + 1'b1;
              wrap_d     = &cur_addr_q;
            end else if ((rem_q - 7'd1) <= GAP && dur_q > GAP) begin
              note_d = 4'd0;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d    = S_IDLE;
      cur_addr_d = '0;
      octave_d   = 4'd0;
      note_d     = 4'd0;
      tick_d     = '0;
      rem_d      = 7'd0;
      wrap_d     = 1'b0;
      strobe_d   = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      octave_q   <= 4'd0;
      note_q     <= 4'd0;
      dur_q      <= 7'd0;
      rem_q      <= 7'd0;
      tick_q     <= '0;
      wrap_q     <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      octave_q   <= octave_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      rem_q      <= rem_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
    end
  end

  assign octave      = octave_q;
  assign note        = note_q;
  assign note_strobe = strobe_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign cur_addr    = cur_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_rtttl_seq_engine.sv
`default_nettype none
// Bench for rtttl_seq_engine: duration table, directed corner sequences and
// random songs compared cycle by cycle against an expected-waveform model.
module tb_rtttl_seq_engine;
  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, stop, pause, loop_en, wr_en;
  logic [15:0] tick_div, wr_data;
  logic [5:0]  wr_addr;
  logic [3:0]  octave, note;
  logic        note_strobe, busy, done;
  logic [5:0]  cur_addr;

  logic        rstn2, start2, wr_en2, zero2;
  logic [15:0] tick_div2, wr_data2;
  logic [1:0]  wr_addr2;
  logic [3:0]  octave2, note2;
  logic        note_strobe2, busy2, done2;
  logic [1:0]  cur_addr2;

  rtttl_seq_engine #(.ADDR_W(6), .TICK_W(16), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .tick_div(tick_div), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .octave(octave), .note(note), .note_strobe(note_strobe),
    .busy(busy), .done(done), .cur_addr(cur_addr)
  );

  rtttl_seq_engine #(.ADDR_W(2), .TICK_W(16), .GAP_TICKS(GAP)) dut2 (
    .clk(clk), .rstn(rstn2), .start(start2), .stop(zero2), .pause(zero2),
    .loop_en(zero2), .tick_div(tick_div2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .octave(octave2), .note(note2), .note_strobe(note_strobe2),
    .busy(busy2), .done(done2), .cur_addr(cur_addr2)
  );

  typedef struct {
    logic [3:0] oct;
    logic [3:0] nt;
    logic       stb;
    logic       bsy;
    logic       dn;
    logic [5:0] addr;
    bit         ca;
  } samp_t;

  typedef struct {
    int dur;
    bit dot;
    int len;
    int nz;
  } dvec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] song [64];
  int          base_t [8] = '{64, 32, 16, 8, 4, 2, 1, 1};
  int          exp_loop [8] = '{0, 1, 2, 0, 1, 2, 0, 1};
  samp_t       exp_q [$];
  int          aq [$];
  dvec_t       dtab [16];
  int          len, nz, bad, prev, strobes, slen, sdiv;
  bit          seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic samp_t mk_s(input int oct, input int nt, input bit stb, input bit bsy,
                                 input bit dn, input int addr, input bit ca);
    samp_t s;
    s.oct  = 4'(oct);
    s.nt   = 4'(nt);
    s.stb  = stb;
    s.bsy  = bsy;
    s.dn   = dn;
    s.addr = 6'(addr);
    s.ca   = ca;
    return s;
  endfunction

  function automatic logic [15:0] mk_e(input bit e, input bit dot, input int dur,
                                       input int oct, input int nt);
    return {e, dot, 3'(dur), 3'b000, 4'(oct), 4'(nt)};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr2(input int a, input logic [15:0] d);
    wr_en2 = 1'b1; wr_addr2 = 2'(a); wr_data2 = d;
    tick();
    wr_en2 = 1'b0;
  endtask

  task automatic load_song(input int n);
    for (int i = 0; i < n; i++) wr(i, song[i]);
  endtask

  // Expected outputs for every cycle after the start edge: one LOAD cycle per
  // entry, then ticks*div PLAY cycles whose last GAP*div cycles are silent.
  task automatic build_model(input int div);
    int d, addr, t, n, g, b;
    logic [3:0] co, cn;
    logic [15:0] e;
    d = (div == 0) ? 1 : div;
    addr = 0; co = 4'd0; cn = 4'd0;
    exp_q.delete();
    exp_q.push_back(mk_s(0, 0, 0, 1, 0, 0, 1));
    for (int k = 0; k < 64; k++) begin
      e = song[addr];
      if (e[15]) begin
        exp_q.push_back(mk_s(0, 0, 0, 0, 1, 0, 0));
        break;
      end
      b = base_t[e[13:11]];
      t = b + (e[14] ? b / 2 : 0);
      n = t * d;
      g = (t > GAP) ? GAP * d : 0;
      for (int c = 0; c < n; c++)
        exp_q.push_back(mk_s(int'(e[7:4]), (c >= n - g) ? 0 : int'(e[3:0]), c == 0, 1, 0, addr, 1));
      co = e[7:4];
      cn = (g > 0) ? 4'd0 : e[3:0];
      addr++;
      exp_q.push_back(mk_s(int'(co), int'(cn), 0, 1, 0, addr, 1));
    end
  endtask

  task automatic run_song(input string name, input int div);
    samp_t s;
    bit ok;
    tick_div = 16'(div);
    build_model(div);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      s = exp_q[i];
      ok = (octave === s.oct) && (note === s.nt) && (note_strobe === s.stb) &&
           (busy === s.bsy) && (done === s.dn) && (!s.ca || cur_addr === s.addr);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s cycle %0d: got oct=%0d note=%0d stb=%0b busy=%0b done=%0b addr=%0d, expected oct=%0d note=%0d stb=%0b busy=%0b done=%0b addr=%0d",
                 name, i, octave, note, note_strobe, busy, done, cur_addr,
                 s.oct, s.nt, s.stb, s.bsy, s.dn, s.addr);
        break;
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    dtab[0]  = '{0, 0, 64, 63}; dtab[1]  = '{0, 1, 96, 95};
    dtab[2]  = '{1, 0, 32, 31}; dtab[3]  = '{1, 1, 48, 47};
    dtab[4]  = '{2, 0, 16, 15}; dtab[5]  = '{2, 1, 24, 23};
    dtab[6]  = '{3, 0, 8, 7};   dtab[7]  = '{3, 1, 12, 11};
    dtab[8]  = '{4, 0, 4, 3};   dtab[9]  = '{4, 1, 6, 5};
    dtab[10] = '{5, 0, 2, 1};   dtab[11] = '{5, 1, 3, 2};
    dtab[12] = '{6, 0, 1, 1};   dtab[13] = '{6, 1, 1, 1};
    dtab[14] = '{7, 0, 1, 1};   dtab[15] = '{7, 1, 1, 1};

    rstn = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; tick_div = 16'd1;
    rstn2 = 1'b0; start2 = 1'b0; wr_en2 = 1'b0; zero2 = 1'b0;
    wr_addr2 = '0; wr_data2 = '0; tick_div2 = 16'd1;
    repeat (3) tick();
    chk("reset_outputs", {octave, note, note_strobe, busy, done, cur_addr}, 0);
    chk("reset_outputs2", {octave2, note2, note_strobe2, busy2, done2, cur_addr2}, 0);
    rstn = 1'b1; rstn2 = 1'b1;
    tick();

    // Single note with gap, tick_div=4.
    song[0] = mk_e(0, 0, 2, 5, 6);
    song[1] = mk_e(1, 0, 0, 0, 0);
    load_song(2);
    run_song("basic_note", 4);

    // Duration/dot table at tick_div=1.
    tick_div = 16'd1;
    for (int i = 0; i < 16; i++) begin
      song[0] = mk_e(0, dtab[i].dot, dtab[i].dur, 5, 9);
      song[1] = mk_e(1, 0, 0, 0, 0);
      load_song(2);
      start = 1'b1; tick(); start = 1'b0; tick();
      chk($sformatf("dur%0d_strobe", i), note_strobe, 1);
      len = 0; nz = 0;
      while (cur_addr == 6'd0 && len < 200) begin
        if (note == 4'd9) nz++;
        len++;
        tick();
      end
      chk($sformatf("dur%0d_len", i), len, dtab[i].len);
      chk($sformatf("dur%0d_sounding", i), nz, dtab[i].nz);
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        tick();
        if (done) seen = 1'b1;
      end
      chk($sformatf("dur%0d_done", i), seen, 1);
      chk($sformatf("dur%0d_idle", i), busy, 0);
    end

    // Looping song: address sequence wraps, never reports done.
    song[0] = mk_e(0, 0, 5, 4, 1);
    song[1] = mk_e(0, 0, 5, 4, 2);
    song[2] = mk_e(1, 0, 0, 0, 0);
    load_song(3);
    tick_div = 16'd1; loop_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    aq.delete(); prev = -1; seen = 1'b0;
    for (int k = 0; k < 200 && aq.size() < 8; k++) begin
      if (done) seen = 1'b1;
      if (int'(cur_addr) != prev) begin
        prev = int'(cur_addr);
        aq.push_back(prev);
      end
      tick();
    end
    chk("loop_addr_count", aq.size(), 8);
    for (int k = 0; k < aq.size() && k < 8; k++) chk($sformatf("loop_addr%0d", k), aq[k], exp_loop[k]);
    chk("loop_no_done", seen, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("loop_stop_busy", busy, 0);
    song[0] = mk_e(1, 0, 0, 0, 0);
    load_song(1);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("loop_end_at0_done", done, 1);
    chk("loop_end_at0_busy", busy, 0);
    loop_en = 1'b0;
    tick();

    // Pause for 10 cycles mid-note stretches the note by exactly 10 cycles.
    song[0] = mk_e(0, 0, 4, 3, 7);
    song[1] = mk_e(1, 0, 0, 0, 0);
    load_song(2);
    tick_div = 16'd2;
    start = 1'b1; tick(); start = 1'b0; tick();
    len = 0; bad = 0;
    while (cur_addr == 6'd0 && len < 100) begin
      if (len == 3) pause = 1'b1;
      if (len == 13) pause = 1'b0;
      if (len >= 3 && len <= 13 && (note !== 4'd7 || octave !== 4'd3 || note_strobe !== 1'b0)) bad++;
      len++;
      tick();
    end
    pause = 1'b0;
    chk("pause_len", len, 18);
    chk("pause_frozen", bad, 0);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("pause_done", seen, 1);

    // Stop mid-note with simultaneous start, then replay from 0.
    song[0] = mk_e(0, 0, 2, 4, 5);
    song[1] = mk_e(1, 0, 0, 0, 0);
    load_song(2);
    tick_div = 16'd2;
    start = 1'b1; tick(); start = 1'b0; tick();
    repeat (5) tick();
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("stop_outputs", {octave, note, busy, cur_addr}, 0);
    bad = 0;
    repeat (5) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    chk("stop_quiet", bad, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("restart_strobe", note_strobe, 1);
    chk("restart_note", {octave, note}, {4'd4, 4'd5});
    chk("restart_addr", cur_addr, 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Random songs against the model.
    for (int r = 0; r < 12; r++) begin
      slen = $urandom_range(2, 6);
      for (int i = 0; i < slen - 1; i++) song[i] = {1'b0, 15'($urandom)};
      song[slen - 1] = {1'b1, 15'($urandom)};
      sdiv = $urandom_range(0, 3);
      load_song(slen);
      run_song($sformatf("rand%0d", r), sdiv);
    end

    // Small memory with no end flag: four entries then done; reset mid-play.
    for (int i = 0; i < 4; i++) wr2(i, mk_e(0, 0, 5, 2, i + 1));
    start2 = 1'b1; tick(); start2 = 1'b0;
    strobes = 0; seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (note_strobe2) strobes++;
      if (done2) seen = 1'b1;
      else tick();
    end
    chk("full_mem_strobes", strobes, 4);
    chk("full_mem_done", seen, 1);
    chk("full_mem_idle", busy2, 0);
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (3) tick();
    chk("midplay_busy2", busy2, 1);
    rstn2 = 1'b0; tick();
    chk("midplay_reset2", {octave2, note2, note_strobe2, busy2, done2, cur_addr2}, 0);
    rstn2 = 1'b1; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
